park_transform: RTL and testbench

Park transform stage that rotates the stationary-frame currents (Ialpha, Ibeta) from the Clarke stage into the rotor frame (Id, Iq) using the electrical angle. It sits directly downstream of the Clarke stage and feeds the d/q current PI controllers. A single time-shared signed multiplier computes the four products, and a quarter-wave sine/cosine lookup supplies the trig terms. The block launches on a rising edge of its enable and emits a one-cycle done strobe.

---
 rtl/park_transform_pkg.sv | 41 ++++
 rtl/park_transform_sin_cos_lut.sv | 44 ++++
 rtl/park_transform.sv | 113 +++++++++++
 tb/tb_park_transform.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/park_transform_pkg.sv
// Shared FOC constants, state encoding and arithmetic helpers for the Park stage.
package park_transform_pkg;

   localparam int W_I        = 12;
   localparam int W_TH       = 12;
   localparam int QUARTER    = 1024;
   localparam int FULL_TURN  = 4096;
   localparam int TRIG_SCALE = 2047;
   localparam int PROD_SHIFT = 11;
   localparam int SAT_MAX    = 2047;
   localparam int SAT_MIN    = -2048;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LUT,
      S_M0,
      S_M1,
      S_M2,
      S_M3,
      S_OUT
   } state_t;

   // Evaluated only at elaboration to build the quarter-wave ROM contents.
   function automatic logic [10:0] quarter_sine(input int k);
      real ang;
      ang = 3.14159265358979323846 / 2.0 * real'(k) / real'(QUARTER);
      return 11'($rtoi(real'(TRIG_SCALE) * $sin(ang) + 0.5));
   endfunction

   function automatic logic [W_I-1:0] sat_word(input logic signed [24:0] acc);
      logic signed [13:0] sh;
      sh = 14'(acc >>> PROD_SHIFT);
      if (int'(sh) > SAT_MAX)
         return W_I'(SAT_MAX);
      else if (int'(sh) < SAT_MIN)
         return W_I'(SAT_MIN);
      else
         return sh[W_I-1:0];
   endfunction

endpackage

// File: rtl/park_transform_sin_cos_lut.sv
// Quarter-wave sine/cosine lookup: dual-read ROM with quadrant fold and sign, one-cycle latency.
module sin_cos_lut
   import park_transform_pkg::*;
(
   input  logic              iClk,
   input  logic [W_TH-1:0]   iTheta,
   output logic [W_I-1:0]    oSin,
   output logic [W_I-1:0]    oCos
);

   logic [10:0]      w_rom [0:QUARTER];
   logic [W_TH-1:0]  w_cos_theta;
   logic [10:0]      w_sin_addr;
   logic [10:0]      w_cos_addr;
   logic [10:0]      w_sin_mag;
   logic [10:0]      w_cos_mag;
   logic [W_I-1:0]   r_sin;
   logic [W_I-1:0]   r_cos;

   for (genvar gi = 0; gi <= QUARTER; gi++) begin : g_rom
      localparam logic [10:0] K_VAL = quarter_sine(gi);
      assign w_rom[gi] = K_VAL;
   end

   // Odd quadrants read the table mirrored about the quarter point.
   function automatic logic [10:0] fold_addr(input logic [10:0] th);
      return th[10] ? (11'(QUARTER) - {1'b0, th[9:0]}) : {1'b0, th[9:0]};
   endfunction

   assign w_cos_theta = iTheta + W_TH'(QUARTER);
   assign w_sin_addr  = fold_addr(iTheta[10:0]);
   assign w_cos_addr  = fold_addr(w_cos_theta[10:0]);
   assign w_sin_mag   = w_rom[w_sin_addr];
   assign w_cos_mag   = w_rom[w_cos_addr];

   always_ff @(posedge iClk) begin
      r_sin <= iTheta[11]      ? -{1'b0, w_sin_mag} : {1'b0, w_sin_mag};
      r_cos <= w_cos_theta[11] ? -{1'b0, w_cos_mag} : {1'b0, w_cos_mag};
   end

   assign oSin = r_sin;
   assign oCos = r_cos;

endmodule

// File: rtl/park_transform.sv
// Park transform: rotates (Ialpha, Ibeta) into (Id, Iq) with one time-shared multiplier.
module park_transform
   import park_transform_pkg::*;
(
   input  logic              iClk,
   input  logic              iRst_n,
   input  logic              iP_en,
   input  logic [W_I-1:0]    iIalpha,
   input  logic [W_I-1:0]    iIbeta,
   input  logic [W_TH-1:0]   iTheta,
   output logic [W_I-1:0]    oId,
   output logic [W_I-1:0]    oIq,
   output logic              oP_done,
   output logic              oBusy
);

   state_t              r_state;
   logic                r_pre;
   logic [W_I-1:0]      r_alpha;
   logic [W_I-1:0]      r_beta;
   logic [W_TH-1:0]     r_theta;
   logic signed [24:0]  r_acc_d;
   logic signed [24:0]  r_acc_q;
   logic [W_I-1:0]      r_id;
   logic [W_I-1:0]      r_iq;
   logic                r_done;
   logic                r_busy;

   logic [W_I-1:0]      w_sin;
   logic [W_I-1:0]      w_cos;
   logic                w_launch;
   logic [W_I-1:0]      w_op_a;
   logic [W_I-1:0]      w_op_b;
   logic signed [23:0]  w_prod;
   logic signed [24:0]  w_prod_ext;

   sin_cos_lut u_lut (
      .iClk   (iClk),
      .iTheta (r_theta),
      .oSin   (w_sin),
      .oCos   (w_cos)
   );

   assign w_launch = !r_pre && iP_en && (r_state == S_IDLE);

   // M0: alpha*cos, M1: beta*sin, M2: alpha*sin, M3: beta*cos
   assign w_op_a = (r_state == S_M0 || r_state == S_M2) ? r_alpha : r_beta;
   assign w_op_b = (r_state == S_M1 || r_state == S_M2) ? w_sin : w_cos;

   assign w_prod     = $signed({{12{w_op_a[W_I-1]}}, w_op_a}) * $signed({{12{w_op_b[W_I-1]}}, w_op_b});
   assign w_prod_ext = {w_prod[23], w_prod};

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_state <= S_IDLE;
         r_pre   <= 1'b0;
         r_alpha <= '0;
         r_beta  <= '0;
         r_theta <= '0;
         r_acc_d <= '0;
         r_acc_q <= '0;
         r_id    <= '0;
         r_iq    <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_pre  <= iP_en;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_busy <= w_launch;
               if (w_launch) begin
                  r_alpha <= iIalpha;
                  r_beta  <= iIbeta;
                  r_theta <= iTheta;
                  r_state <= S_LUT;
               end
            end
            S_LUT: r_state <= S_M0;
            S_M0: begin
               r_acc_d <= w_prod_ext;
               r_state <= S_M1;
            end
            S_M1: begin
               r_acc_d <= r_acc_d + w_prod_ext;
               r_state <= S_M2;
            end
            S_M2: begin
               r_acc_q <= -w_prod_ext;
               r_state <= S_M3;
            end
            S_M3: begin
               r_acc_q <= r_acc_q + w_prod_ext;
               r_state <= S_OUT;
            end
            S_OUT: begin
               // Busy stays high through the done cycle; IDLE drops it next edge.
               r_id    <= sat_word(r_acc_d);
               r_iq    <= sat_word(r_acc_q);
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign oId     = r_id;
   assign oIq     = r_iq;
   assign oP_done = r_done;
   assign oBusy   = r_busy;

endmodule

// File: tb/tb_park_transform.sv
// Scoreboard bench for park_transform: directed vectors, abort/ignore cases and a full angle sweep.
module tb_park_transform;

   logic        iClk = 1'b0;
   logic        iRst_n = 1'b0;
   logic        iP_en = 1'b0;
   logic [11:0] iIalpha = '0;
   logic [11:0] iIbeta = '0;
   logic [11:0] iTheta = '0;
   logic [11:0] oId;
   logic [11:0] oIq;
   logic        oP_done;
   logic        oBusy;

   always #5 iClk = ~iClk;

   park_transform dut (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .iP_en   (iP_en),
      .iIalpha (iIalpha),
      .iIbeta  (iIbeta),
      .iTheta  (iTheta),
      .oId     (oId),
      .oIq     (oIq),
      .oP_done (oP_done),
      .oBusy   (oBusy)
   );

   typedef struct {
      string name;
      int    id;
      int    iq;
      int    cyc;
   } exp_t;

   typedef struct {
      int a;
      int b;
      int th;
      int id;
      int iq;
   } vec_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;

   always @(posedge iClk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Monitor: every done strobe must match the oldest outstanding expectation.
   always @(negedge iClk) begin
      exp_t e;
      if (iRst_n && oP_done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            $display("txn %s id=%0d iq=%0d cyc=%0d", e.name, int'($signed(oId)), int'($signed(oIq)), cyc);
            check({e.name, "_id"}, int'($signed(oId)), e.id);
            check({e.name, "_iq"}, int'($signed(oIq)), e.iq);
            check({e.name, "_latency"}, cyc, e.cyc);
         end
      end
   end

   function automatic int tbl(input int k);
      return $rtoi(2047.0 * $sin(3.14159265358979323846 * real'(k) / 2048.0) + 0.5);
   endfunction

   function automatic int sin_m(input int th);
      int t, i;
      t = th & 4095;
      i = t & 1023;
      case (t >> 10)
         0:       return tbl(i);
         1:       return tbl(1024 - i);
         2:       return -tbl(i);
         default: return -tbl(1024 - i);
      endcase
   endfunction

   function automatic int sat(input int v);
      return (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
   endfunction

   task automatic set_inputs(input int a, input int b, input int th);
      iIalpha = 12'(a);
      iIbeta  = 12'(b);
      iTheta  = 12'(th);
   endtask

   // Starts at a negedge, raises iP_en so the next posedge is the capture edge.
   task automatic launch(input int a, input int b, input int th, input string name,
                         input int eid, input int eiq);
      @(negedge iClk);
      set_inputs(a, b, th);
      iP_en = 1'b1;
      sb.push_back('{name, eid, eiq, cyc + 7});
      @(negedge iClk);
      iP_en = 1'b0;
      check({name, "_busy_e0"}, int'(oBusy), 1);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge iClk);
         n++;
      end
      if (sb.size() != 0) begin
         check({name, "_timeout"}, sb.size(), 0);
         sb.delete();
      end
   endtask

   vec_t dir[4];

   initial begin
      int c, s, eid, eiq;

      dir[0] = '{1000, -500, 0,    999,  -500};
      dir[1] = '{1000, -500, 1024, -500, -1000};
      dir[2] = '{2047, 2047, 512,  2047, 0};
      dir[3] = '{-2048, 0,   2048, 2047, 0};

      repeat (3) @(negedge iClk);
      check("rst_id",   int'(oId), 0);
      check("rst_iq",   int'(oIq), 0);
      check("rst_done", int'(oP_done), 0);
      check("rst_busy", int'(oBusy), 0);
      iRst_n = 1'b1;

      foreach (dir[k]) begin
         launch(dir[k].a, dir[k].b, dir[k].th, $sformatf("dir%0d", k), dir[k].id, dir[k].iq);
         drain($sformatf("dir%0d", k));
         @(negedge iClk);
         check($sformatf("dir%0d_busy_after", k), int'(oBusy), 0);
         check($sformatf("dir%0d_hold_id", k), int'($signed(oId)), dir[k].id);
      end

      // Second rising edge at E3 is dropped; inputs changed mid-transform are ignored.
      @(negedge iClk);
      set_inputs(1000, -500, 1024);
      iP_en = 1'b1;
      sb.push_back('{"ign_first", -500, -1000, cyc + 7});
      @(negedge iClk);
      iP_en = 1'b0;
      repeat (2) @(negedge iClk);
      set_inputs(-2048, 2047, 3000);
      iP_en = 1'b1;
      @(negedge iClk);
      iP_en = 1'b0;
      repeat (4) @(negedge iClk);
      set_inputs(-300, 700, 0);
      iP_en = 1'b1;
      sb.push_back('{"relaunch_e8", -300, 699, cyc + 7});
      @(negedge iClk);
      iP_en = 1'b0;
      drain("relaunch_e8");

      // Reset at E3 aborts the transform with no strobe.
      @(negedge iClk);
      set_inputs(1000, -500, 0);
      iP_en = 1'b1;
      @(negedge iClk);
      iP_en = 1'b0;
      repeat (2) @(negedge iClk);
      @(posedge iClk);
      #1 iRst_n = 1'b0;
      #1;
      check("abort_id",   int'(oId), 0);
      check("abort_iq",   int'(oIq), 0);
      check("abort_done", int'(oP_done), 0);
      check("abort_busy", int'(oBusy), 0);
      repeat (3) @(negedge iClk);
      iRst_n = 1'b1;
      repeat (8) @(negedge iClk);
      check("abort_busy_after", int'(oBusy), 0);
      launch(1000, -500, 0, "post_reset", 999, -500);
      drain("post_reset");

      for (int th = 0; th < 4096; th++) begin
         c   = sin_m(th + 1024);
         s   = sin_m(th);
         eid = sat((1000 * c) >>> 11);
         eiq = sat((-(1000 * s)) >>> 11);
         launch(1000, 0, th, $sformatf("sweep%0d", th), eid, eiq);
         drain($sformatf("sweep%0d", th));
      end

      repeat (4) @(negedge iClk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
